// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access: req/ack handshake with variable latency, stall
// generation toward EX/MEM, and the registered write-back result toward WB.
module mem_access_unit #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_1_in,
  input  logic [31:0]       data_2_in,
  input  logic [4:0]        Rd_in,
  input  logic              MEM_wen_in,
  input  logic              WB_sel_in,
  input  logic              Reg_WB_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic [31:0]       wb_data_out,
  output logic [4:0]        Rd_out,
  output logic              Reg_WB_out,
  output logic              mem_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             access_op, misalign;
  logic             req_c, stall_c, err_c, tmo;

  assign access_op = MEM_wen_in | WB_sel_in;
  assign misalign  = access_op & (data_1_in[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    err_c     = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (misalign) begin
          err_c = 1'b1;
        end else if (access_op) begin
          req_c   = 1'b1;
          stall_c = !dmem_ack;
          if (!dmem_ack) begin
            state_nxt = S_WAIT;
            count_nxt = '0;
          end
        end
      end
      S_WAIT: begin
        req_c   = 1'b1;
        tmo     = (count == CNT_LAST) & !dmem_ack;
        stall_c = !dmem_ack & !tmo;
        if (dmem_ack) begin
          state_nxt = S_IDLE;
        end else if (tmo) begin
          state_nxt = S_IDLE;
          err_c     = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset must drop the request and stall in the same cycle, not at the next edge.
  assign dmem_req   = req_c & !reset;
  assign stall      = stall_c & !reset;
  assign dmem_we    = dmem_req & MEM_wen_in;
  assign dmem_addr  = data_1_in[ADDR_W+1:2];
  assign dmem_wdata = data_2_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_out <= '0;
      Rd_out      <= '0;
      Reg_WB_out  <= 1'b0;
      mem_err_out <= 1'b0;
    end else begin
      mem_err_out <= err_c;
      if (!stall_c && !err_c) begin
        Rd_out      <= Rd_in;
        Reg_WB_out  <= Reg_WB_in;
        wb_data_out <= WB_sel_in ? dmem_rdata : data_1_in;
      end else begin
        Reg_WB_out  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs the data-memory load or store for the instruction currently held in EX/MEM, using a req/ack handshake with variable latency.
- Drives `stall` back to the EX/MEM register (and upstream registers) while an access is outstanding.
- Registers the write-back result toward the WB stage; non-memory instructions pass through with one-cycle latency.

Parameters:
- ADDR_W, 10, width of the word address to data memory (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 16, maximum cycles spent in WAIT without ack before the access is aborted; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_1_in  in  32  ALU result: byte address for load/store, WB data otherwise.
- data_2_in  in  32  store data.
- Rd_in  in  5  destination register.
- MEM_wen_in  in  1  store.
- WB_sel_in  in  1  1 = load (WB takes memory data), 0 = WB takes data_1_in.
- Reg_WB_in  in  1  register write enable.
- dmem_req  out  1  access request (combinational).
- dmem_we  out  1  1 = write (combinational, = MEM_wen_in while dmem_req).
- dmem_addr  out  ADDR_W  word address = data_1_in[ADDR_W+1:2].
- dmem_wdata  out  32  = data_2_in.
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  load data.
- stall  out  1  hold EX/MEM and upstream (combinational).
- wb_data_out  out  32  registered write-back data.
- Rd_out  out  5  registered destination.
- Reg_WB_out  out  1  registered write enable (0 = bubble).
- mem_err_out  out  1  one-cycle pulse on misaligned access or timeout.

Behaviour:
- Reset value of every registered output is 0: wb_data_out, Rd_out, Reg_WB_out, mem_err_out, FSM state = IDLE, counter = 0. While reset is high, dmem_req, dmem_we and stall are forced to 0.
- Definitions:
  - access_op = MEM_wen_in | WB_sel_in.
  - misalign = access_op & (data_1_in[1:0] != 0).
- FSM state IDLE:
  - Pass-through: if access_op = 0, then dmem_req = 0 and stall = 0.
  - Misaligned: if misalign, then dmem_req = 0 and stall = 0. On the next edge, output a bubble with mem_err_out = 1. Stay in IDLE.
  - Aligned access: dmem_req = 1 and stall = !dmem_ack. If dmem_ack is high, the access completes in zero wait states. Otherwise go to WAIT with the counter cleared to 0.
- FSM state WAIT:
  - dmem_req = 1.
  - tmo = (count == TIMEOUT-1) & !dmem_ack.
  - stall = !dmem_ack & !tmo.
  - Counter increments each cycle without ack.
  - On ack: complete and return to IDLE.
  - On tmo: output a bubble, pulse mem_err_out, return to IDLE.
  - Total request cycles on timeout = TIMEOUT + 1.
- Output register, on each edge with stall = 0 and no error:
  - Rd_out <= Rd_in.
  - Reg_WB_out <= Reg_WB_in.
  - wb_data_out <= WB_sel_in ? dmem_rdata : data_1_in.
- On edges with stall = 1, or on an error: Reg_WB_out <= 0 (bubble). Rd_out and wb_data_out are don't-care but are held.
- mem_err_out is high only in the cycle after the error edge.
- EX/MEM inputs are stable while stall = 1, so dmem_addr, dmem_wdata and dmem_we stay stable for the whole request.
- Stores with Reg_WB_in = 1 write data_1_in back; no special casing.
- Reset mid-access (asynchronous): outputs and state clear immediately, dmem_req drops in the same cycle, and any late ack in IDLE with access_op = 0 is ignored.
- Back-to-back accesses: the cycle after an ack edge may present a new access in IDLE; a new request starts with no dead cycle.

Test Plan:
- ALU pass-through: data_1_in=0x00001234, Rd_in=5, Reg_WB_in=1, WB_sel_in=0, MEM_wen_in=0 → stall and dmem_req stay 0; after one edge wb_data_out=0x00001234, Rd_out=5, Reg_WB_out=1.
- Zero-wait load: WB_sel_in=1, data_1_in=0x40, dmem_ack=1 in the same cycle with dmem_rdata=0xDEADBEEF → dmem_addr=0x10, stall=0; next edge wb_data_out=0xDEADBEEF, Reg_WB_out=1.
- Store with ack on the 3rd request cycle: MEM_wen_in=1, data_2_in=0xCAFEF00D, address 0x8 → dmem_req=dmem_we=1 for 3 cycles with dmem_addr=2 and dmem_wdata=0xCAFEF00D; stall high for 2 cycles; Reg_WB_out=0 during stall; stall drops on the ack cycle.
- Timeout, TIMEOUT=16, load never acked → dmem_req high 17 cycles, stall high 16; mem_err_out pulses once, Reg_WB_out=0, FSM back in IDLE.
- Misaligned load at 0x42 → dmem_req never asserts, stall=0; next cycle mem_err_out=1 and Reg_WB_out=0.
- Reset asserted mid-cycle during WAIT → dmem_req, stall and all registered outputs go to 0 before the next clock edge; after release, a fresh aligned load completes normally.
